// File: rtl/banco_reg_wr_pkg.sv
// banco_reg_wr_pkg
// Shared definitions for the multicycle datapath register bank and the
// control unit: register index type, architectural register numbers, the
// stack-pointer reset value and the selector codes of the write-address mux
// that feeds banco_reg_wr.
package banco_reg_wr_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t    REG_ZERO     = 5'd0;
  localparam reg_idx_t    REG_SP       = 5'd29;
  localparam reg_idx_t    REG_RA       = 5'd31;
  localparam int unsigned SP_RESET_VAL = 227;
  localparam int unsigned NUM_REGS     = 32;

  // Selector codes of the upstream write-address mux (rt / $0 / rd / $ra).
  typedef enum logic [1:0] {
    WSEL_RT   = 2'd0,
    WSEL_ZERO = 2'd1,
    WSEL_RD   = 2'd2,
    WSEL_RA   = 2'd3
  } wsel_e;

  // A write only has an architectural effect when it does not target $0.
  function automatic logic is_eff_write(input logic we, input reg_idx_t idx);
    return we && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/banco_reg_rport.sv
// banco_reg_rport
// One registered read port of the register bank.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       latch a new value on this edge
//   addr_i       read index
//   stored_i     value currently held in the array at addr_i
//   fwd_en_i     an effective write happens on this edge
//   fwd_addr_i   index of that write
//   fwd_data_i   value of that write
//   data_o       registered read data
module banco_reg_rport
  import banco_reg_wr_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  reg_idx_t          addr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              fwd_en_i,
  input  reg_idx_t          fwd_addr_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // $0 wins over forwarding; fwd_en_i never flags $0 anyway, but the zero
  // check keeps the port correct independent of how the array resets.
  always_comb begin
    data_d = stored_i;
    if (addr_i == REG_ZERO) begin
      data_d = '0;
    end else if (fwd_en_i && (fwd_addr_i == addr_i)) begin
      data_d = fwd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/banco_reg_wr.sv
// banco_reg_wr
// 32 x DATA_W register bank with two load-enabled registered read ports,
// same-edge write forwarding, a written-since-reset mask and a saturating
// count of effective writes.
// Ports:
//   clk           system clock (rising edge)
//   reset         asynchronous active-low reset
//   reg_write     write enable
//   write_reg     write index (from the write-address mux)
//   write_data    write value
//   read_reg1/2   read indices (rs / rt)
//   read_load     latch both read ports
//   read_data1/2  registered read data
//   written_mask  bit i set once register i has been written since reset
//   write_count   saturating count of effective writes
module banco_reg_wr
  import banco_reg_wr_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SP_INDEX = 29,
  parameter int unsigned SP_RESET = SP_RESET_VAL,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  reg_idx_t          write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  reg_idx_t          read_reg1,
  input  reg_idx_t          read_reg2,
  input  logic              read_load,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [31:0]       written_mask,
  output logic [CNT_W-1:0]  write_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [31:0]       mask_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_eff;

  assign we_eff = is_eff_write(reg_write, write_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (we_eff) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Bit 0 can never be set because $0 writes are not effective.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else if (we_eff) begin
      mask_q[write_reg] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (we_eff && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  banco_reg_rport #(.DATA_W(DATA_W)) u_rport1 (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (read_load),
    .addr_i     (read_reg1),
    .stored_i   (regs_q[read_reg1]),
    .fwd_en_i   (we_eff),
    .fwd_addr_i (write_reg),
    .fwd_data_i (write_data),
    .data_o     (read_data1)
  );

  banco_reg_rport #(.DATA_W(DATA_W)) u_rport2 (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (read_load),
    .addr_i     (read_reg2),
    .stored_i   (regs_q[read_reg2]),
    .fwd_en_i   (we_eff),
    .fwd_addr_i (write_reg),
    .fwd_data_i (write_data),
    .data_o     (read_data2)
  );

  assign written_mask = mask_q;
  assign write_count  = cnt_q;

endmodule

// File: doc/banco_reg_wr.md
# banco_reg_wr

Register bank of the multicycle datapath, sitting directly downstream of the write-address select mux. It holds 32 general registers of 32 bits and takes its 5-bit write index from that mux, already resolved to rt, $0, rd or $ra. Reads are registered with a load enable, with same-edge write forwarding. A written-since-reset mask and a saturating write counter serve the control unit and debug.

## Interface
Parameters:
- DATA_W, 32, register width.
- SP_INDEX, 29, index of the stack-pointer register.
- SP_RESET, 227, reset value of the stack pointer.
- CNT_W, 16, width of the write counter.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- reg_write  in  1  write enable from the control unit.
- write_reg  in  5  write index from the write-address mux.
- write_data  in  DATA_W  write value.
- read_reg1  in  5  read index, port 1 (rs).
- read_reg2  in  5  read index, port 2 (rt).
- read_load  in  1  latch both read ports on this edge.
- read_data1  out  DATA_W  registered read data, port 1.
- read_data2  out  DATA_W  registered read data, port 2.
- written_mask  out  32  bit i set once register i has been written since reset.
- write_count  out  CNT_W  count of effective writes, saturating.

## Operation
- Effective write: reg_write=1 and write_reg≠0. The register file entry write_reg takes write_data.
- Effects of an effective write:
  - written_mask[write_reg] is set.
  - write_count increments unless it is already all-ones, where it holds.
- Writes to $0 are discarded:
  - no storage change, no mask bit, no count.
  - Register 0 always reads 0; written_mask[0] is constant 0.
- Read port k when read_load=1:
  - read_datak latches reg[read_regk].
  - If read_regk=0, it latches 0.
  - Otherwise, if an effective write targets read_regk on the same edge, it latches write_data (forwarding).
  - Otherwise it latches the stored value.
- read_load=0: both read_data outputs hold.
- Both ports may address the same register; both receive the same (possibly forwarded) value.
- Reset values:
  - All registers 0 except reg[SP_INDEX]=SP_RESET.
  - read_data1=read_data2=0, written_mask=0, write_count=0.
- No state machine. State: the 32×DATA_W array, two output registers, the mask and the counter.

## Timing
- Write latency: one edge. A value written at edge N is readable by a read_load at edge N (via forwarding) or at any later edge.
- Read latency: one cycle. read_data is valid after the edge where read_load=1.
- Reset asserted clears all state immediately, with no clock needed.
- While reset is low, all writes and loads are ignored.
- The first effective edge is the first rising edge after reset is released.
- write_reg, write_data, read_reg* and the enables must be stable around the rising edge. They are driven from registers and control-unit outputs, so there is no combinational loop.
- Saturation boundary: at write_count=2^CNT_W−1, further writes leave it unchanged. It never wraps.

## Structure
- Shared package holds:
  - REG_ZERO=0, REG_SP=29, REG_RA=31.
  - SP_RESET_VAL=227.
  - The 5-bit register-index type.
- The write-index encodings of the upstream mux (rt/$0/rd/$ra selector codes) also live in that package, so the control unit and both blocks share one definition.
- One natural sub-module, banco_reg_rport, instantiated twice. Each instance performs:
  - the zero check,
  - the forwarding compare,
  - the load-enabled output register.

## Test plan
- Reset then release → read_load with read_reg1=29, read_reg2=5 gives read_data1=227, read_data2=0; written_mask=0; write_count=0.
- Write 0xDEADBEEF to reg 8, next cycle read_load with read_reg1=8 → read_data1=0xDEADBEEF; written_mask[8]=1; write_count=1.
- Write 0x1234 to reg 0 → reading reg 0 gives 0; written_mask[0]=0; write_count unchanged.
- Same edge: write 0xA5A5A5A5 to reg 31 with read_load, read_reg1=read_reg2=31 → both outputs 0xA5A5A5A5 (forwarded).
- With CNT_W=4, perform 20 writes to reg 3 → write_count saturates at 15. Assert reset mid-sequence → all outputs return to reset values without a clock edge.
